gtx_tx_framer: RTL

GTX_TX_FRAMER -- requirements
Module: gtx_tx_framer

---
 rtl/gtx_kcode_pkg.sv | 41 ++++
 rtl/gtx_cc_timer.sv | 52 +++++
 rtl/gtx_tx_framer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gtx_kcode_pkg.sv
// gtx_kcode_pkg
// Shared definitions for the GTX 8b/10b framing link: the four control
// words, the K-flag patterns, the transmit FSM state encoding and a
// legality check for a (word, K-flag) pair. The transmit framer and the
// receive-side K-code check both import this package so they cannot
// drift apart.
package gtx_kcode_pkg;

   // Control words; each byte is a legal 8b/10b K character
   // (K28.5/K28.6, K28.1, K28.3/K28.4, K28.0).
   localparam logic [15:0] K_IDLE = 16'hBCDC;
   localparam logic [15:0] K_SOF  = 16'h3C3C;
   localparam logic [15:0] K_EOF  = 16'h7C9C;
   localparam logic [15:0] K_CC   = 16'h1C1C;

   // K flags: payload words carry no K byte, control words two.
   localparam logic [1:0] KF_NONE = 2'b00;
   localparam logic [1:0] KF_BOTH = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_EOF  = 2'd2,
      S_CC   = 2'd3
   } tx_state_e;

   // A word is legal on the link if it is payload (no K flags) or one of
   // the four control words flagged on both bytes. Mixed flags never occur.
   function automatic logic kword_legal(input logic [15:0] word,
                                        input logic [1:0]  k);
      logic ok;
      case (k)
         KF_NONE: ok = 1'b1;
         KF_BOTH: ok = (word == K_IDLE) || (word == K_SOF) ||
                       (word == K_EOF)  || (word == K_CC);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/gtx_cc_timer.sv
// gtx_cc_timer
// Free-running clock-correction interval timer with a sticky request flag.
// The counter runs 0..CC_PERIOD-1; every wrap raises pending. The framer
// pulses clear when it starts a CC insertion. A wrap always wins over a
// simultaneous clear, and requests never accumulate beyond one.
//
// Ports:
//   clk     - TXUSRCLK2
//   rst     - synchronous active-high reset (counter 0, pending 0)
//   clear   - acknowledge: a CC insertion is starting this cycle
//   pending - a clock-correction sequence is owed
module gtx_cc_timer #(
   parameter int CC_PERIOD = 5000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic pending
);

   localparam logic [15:0] LAST_COUNT = 16'(CC_PERIOD - 1);

   logic [15:0] count_r;
   logic        pending_r;
   logic        wrap_s;

   assign wrap_s  = (count_r == LAST_COUNT);
   assign pending = pending_r;

   // Interval counter and sticky request flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r   <= 16'd0;
         pending_r <= 1'b0;
      end else begin
         if (wrap_s) begin
            count_r <= 16'd0;
         end else begin
            count_r <= count_r + 16'd1;
         end
         // Wrap takes priority so a request landing on the clear edge survives.
         if (wrap_s) begin
            pending_r <= 1'b1;
         end else if (clear) begin
            pending_r <= 1'b0;
         end else begin
            pending_r <= pending_r;
         end
      end
   end

endmodule

// File: rtl/gtx_tx_framer.sv
// gtx_tx_framer
// Wraps upstream 16-bit payload into SOF ... EOF frames for a GTX
// transmitter, fills gaps with IDLE and inserts periodic clock-correction
// (CC) sequences only between frames.
//
// Ports:
//   clk       - TXUSRCLK2, all logic on the rising edge
//   rst       - synchronous active-high reset; aborts any frame in flight
//   tx_data   - payload word, byte [7:0] sent first
//   tx_valid  - tx_data/tx_last valid
//   tx_last   - current word ends the frame
//   tx_ready  - word accepted this cycle (decoded from state only)
//   gtx_tx    - registered word to GTX TXDATA
//   charisk   - registered K flags (bit0 -> [7:0], bit1 -> [15:8])
//   frame_cnt - registered count of completed frames, wraps at 16 bits
module gtx_tx_framer
   import gtx_kcode_pkg::*;
#(
   parameter int CC_PERIOD = 5000,
   parameter int CC_LEN    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] tx_data,
   input  logic        tx_valid,
   input  logic        tx_last,
   output logic        tx_ready,
   output logic [15:0] gtx_tx,
   output logic [1:0]  charisk,
   output logic [15:0] frame_cnt
);

   // CC words still owed after the one emitted on leaving S_IDLE.
   localparam logic [3:0] CC_EXTRA = 4'(CC_LEN - 1);

   tx_state_e   state_r;
   tx_state_e   state_next_s;
   logic [15:0] gtx_tx_r;
   logic [15:0] gtx_tx_next_s;
   logic [1:0]  charisk_r;
   logic [1:0]  charisk_next_s;
   logic [15:0] frame_cnt_r;
   logic        frame_inc_s;
   logic [3:0]  cc_left_r;
   logic [3:0]  cc_left_next_s;
   logic        cc_clear_s;
   logic        cc_pending_s;

   gtx_cc_timer #(
      .CC_PERIOD (CC_PERIOD)
   ) u_cc_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (cc_clear_s),
      .pending (cc_pending_s)
   );

   // Upstream may only present words while a frame body is open.
   assign tx_ready  = (state_r == S_DATA);
   assign gtx_tx    = gtx_tx_r;
   assign charisk   = charisk_r;
   assign frame_cnt = frame_cnt_r;

   // Next state and next output word; the outputs are registered with the state.
   always_comb begin
      state_next_s   = state_r;
      gtx_tx_next_s  = K_IDLE;
      charisk_next_s = KF_BOTH;
      cc_left_next_s = cc_left_r;
      cc_clear_s     = 1'b0;
      frame_inc_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            // A pending CC beats a waiting frame so it is never starved.
            if (cc_pending_s) begin
               gtx_tx_next_s  = K_CC;
               cc_left_next_s = CC_EXTRA;
               cc_clear_s     = 1'b1;
               state_next_s   = S_CC;
            end else if (tx_valid) begin
               gtx_tx_next_s = K_SOF;
               state_next_s  = S_DATA;
            end else begin
               gtx_tx_next_s = K_IDLE;
            end
         end
         S_DATA: begin
            if (tx_valid) begin
               gtx_tx_next_s  = tx_data;
               charisk_next_s = KF_NONE;
               if (tx_last) begin
                  state_next_s = S_EOF;
               end else begin
                  state_next_s = S_DATA;
               end
            end else begin
               gtx_tx_next_s = K_IDLE;
            end
         end
         S_EOF: begin
            gtx_tx_next_s = K_EOF;
            frame_inc_s   = 1'b1;
            state_next_s  = S_IDLE;
         end
         S_CC: begin
            // With CC_LEN=1 nothing is owed and this cycle fills with IDLE.
            if (cc_left_r != 4'd0) begin
               gtx_tx_next_s  = K_CC;
               cc_left_next_s = cc_left_r - 4'd1;
               if (cc_left_r == 4'd1) begin
                  state_next_s = S_IDLE;
               end else begin
                  state_next_s = S_CC;
               end
            end else begin
               gtx_tx_next_s = K_IDLE;
               state_next_s  = S_IDLE;
            end
         end
         default: begin
            gtx_tx_next_s = K_IDLE;
            state_next_s  = S_IDLE;
         end
      endcase
   end

   // State, output word/flags, CC run length and frame counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         gtx_tx_r    <= K_IDLE;
         charisk_r   <= KF_BOTH;
         cc_left_r   <= 4'd0;
         frame_cnt_r <= 16'd0;
      end else begin
         state_r   <= state_next_s;
         gtx_tx_r  <= gtx_tx_next_s;
         charisk_r <= charisk_next_s;
         cc_left_r <= cc_left_next_s;
         if (frame_inc_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

endmodule
